// File: rtl/bcd2bin_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd2bin_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int         BCD_DIGIT_W = 4;
   localparam logic [3:0] BCD_CORR    = 4'd3;
   localparam logic [3:0] BCD_THRESH  = 4'd8;

   function automatic logic bcd_valid(input logic [3:0] digit);
      return (digit <= 4'd9);
   endfunction

endpackage

// File: rtl/bcd2bin_seq_digit_corr.sv
// Per-digit reverse double-dabble correction: digits of 8 or more lose 3.
module bcd_digit_corr
   import bcd2bin_seq_pkg::*;
(
   input  logic [3:0] digit,
   output logic [3:0] digit_corr
);

   assign digit_corr = (digit >= BCD_THRESH) ? (digit - BCD_CORR) : digit;

endmodule

// File: rtl/bcd2bin_seq.sv
// Iterative BCD-to-binary converter, one result bit per clock, start/busy/done handshake.
// Build option: define SIGNED_OUT_EN for a two's-complement OUT_W+1 bit result using sign_in.
module bcd2bin_seq
   import bcd2bin_seq_pkg::*;
#(
   parameter int NDIG  = 5,
   parameter int OUT_W = 17
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [BCD_DIGIT_W*NDIG-1:0] bcd_in,
   input  logic                        sign_in,
   output logic                        busy,
   output logic                        done,
`ifdef SIGNED_OUT_EN
   output logic [OUT_W:0]              bin_out,
`else
   output logic [OUT_W-1:0]            bin_out,
`endif
   output logic                        ovf,
   output logic                        bad_digit
);

   localparam int W     = BCD_DIGIT_W * NDIG;
   localparam int CNT_W = $clog2(W);

   state_t             state, state_nxt;
   logic [W-1:0]       bcd_reg, bin_reg;
   logic [CNT_W-1:0]   cnt;
   logic [2*W-1:0]     shifted;
   logic [W-1:0]       bcd_corr;
   logic               last;
   logic               accept;
   logic               bad_nxt;
   logic               ovf_nxt;

   assign accept  = (state == IDLE) && start;
   assign last    = (cnt == CNT_W'(W - 1));
   assign shifted = {bcd_reg, bin_reg} >> 1;
   assign busy    = (state == SHIFT) || (state == DONE);
   assign done    = (state == DONE);

   for (genvar g = 0; g < NDIG; g++) begin : g_corr
      bcd_digit_corr u_corr (
         .digit      (shifted[W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
         .digit_corr (bcd_corr[BCD_DIGIT_W*g +: BCD_DIGIT_W])
      );
   end

   // Bits above OUT_W that survive the last shift mean the value does not fit.
   if (OUT_W < W) begin : g_ovf
      assign ovf_nxt = |shifted[W-1:OUT_W];
   end else begin : g_no_ovf
      assign ovf_nxt = 1'b0;
   end

   always_comb begin
      bad_nxt = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (!bcd_valid(bcd_in[BCD_DIGIT_W*i +: BCD_DIGIT_W])) bad_nxt = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Datapath shift registers; the correction result on the final shift is never used.
   always_ff @(posedge clk) begin
      if (accept) begin
         bcd_reg <= bcd_in;
         bin_reg <= '0;
      end else if (state == SHIFT) begin
         bcd_reg <= bcd_corr;
         bin_reg <= shifted[W-1:0];
      end
   end

`ifdef SIGNED_OUT_EN
   logic          sign_reg;
   logic [W:0]    mag_x;
   logic [OUT_W:0] res_nxt;

   assign mag_x   = {1'b0, shifted[W-1:0]};
   assign res_nxt = (sign_reg && (shifted[W-1:0] != '0)) ? -mag_x[OUT_W:0] : mag_x[OUT_W:0];

   always_ff @(posedge clk) begin
      if (accept) sign_reg <= sign_in;
   end
`else
   logic             unused_sign;
   logic [OUT_W-1:0] res_nxt;

   assign unused_sign = sign_in;
   assign res_nxt     = shifted[OUT_W-1:0];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         bin_out   <= '0;
         ovf       <= 1'b0;
         bad_digit <= 1'b0;
      end else begin
         if (accept) begin
            cnt       <= '0;
            bad_digit <= bad_nxt;
         end else if (state == SHIFT) begin
            cnt <= cnt + 1'b1;
            if (last) begin
               bin_out <= res_nxt;
               ovf     <= ovf_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Randomized self-checking bench for bcd2bin_seq (unsigned build, OUT_W=17 and OUT_W=16).
module tb_bcd2bin_seq;

   logic        clk = 1'b0;
   logic        rst, start, sign_in;
   logic [19:0] bcd_in;
   logic        busy_a, done_a, ovf_a, bad_a;
   logic [16:0] bin_a;
   logic        busy_b, done_b, ovf_b, bad_b;
   logic [15:0] bin_b;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   bcd2bin_seq #(.NDIG(5), .OUT_W(17)) u_dut_a (
      .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in), .sign_in(sign_in),
      .busy(busy_a), .done(done_a), .bin_out(bin_a), .ovf(ovf_a), .bad_digit(bad_a)
   );

   bcd2bin_seq #(.NDIG(5), .OUT_W(16)) u_dut_b (
      .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in), .sign_in(sign_in),
      .busy(busy_b), .done(done_b), .bin_out(bin_b), .ovf(ovf_b), .bad_digit(bad_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int bcd_value(input logic [19:0] b);
      int v = 0;
      for (int i = 4; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
      return v;
   endfunction

   function automatic bit has_bad(input logic [19:0] b);
      for (int i = 0; i < 5; i++) if (b[4*i +: 4] > 4'd9) return 1'b1;
      return 1'b0;
   endfunction

   task automatic convert(input logic [19:0] bcd, input string tag);
      int n;
      int v;
      bit bad;
      @(negedge clk);
      bcd_in  = bcd;
      sign_in = 1'($urandom_range(0, 1));
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      bad = has_bad(bcd);
      v   = bcd_value(bcd);
      check({tag, "_busy"}, 32'(busy_a), 32'd1);
      check({tag, "_bad_a"}, 32'(bad_a), 32'(bad));
      check({tag, "_bad_b"}, 32'(bad_b), 32'(bad));
      n = 0;
      while (!done_a && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_latency"}, 32'(n), 32'd20);
      check({tag, "_done_b"}, 32'(done_b), 32'd1);
      if (!bad) begin
         check({tag, "_bin_a"}, 32'(bin_a), 32'(v % (1 << 17)));
         check({tag, "_ovf_a"}, 32'(ovf_a), 32'(v >= (1 << 17)));
         check({tag, "_bin_b"}, 32'(bin_b), 32'(v % (1 << 16)));
         check({tag, "_ovf_b"}, 32'(ovf_b), 32'(v >= (1 << 16)));
      end
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 32'(done_a), 32'd0);
      check({tag, "_idle"}, 32'(busy_a), 32'd0);
      if (!bad) check({tag, "_hold"}, 32'(bin_a), 32'(v % (1 << 17)));
   endtask

   initial begin
      logic [19:0] r;
      int          ndone;
      int          last_done;
      rst = 1'b1; start = 1'b0; sign_in = 1'b0; bcd_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      check("rst_bin", 32'(bin_a), 32'd0);
      check("rst_ovf", 32'(ovf_a), 32'd0);
      check("rst_bad", 32'(bad_a), 32'd0);
      @(negedge clk); rst = 1'b0;

      convert(20'h00255, "c255");
      convert(20'h99999, "c99999");
      convert(20'h0001A, "cbad");
      convert(20'h00000, "czero");
      convert(20'h65536, "c65536");
      convert(20'h65535, "c65535");

      for (int k = 0; k < 12; k++) begin
         for (int d = 0; d < 5; d++) r[4*d +: 4] = 4'($urandom_range(0, 9));
         if ($urandom_range(0, 3) == 0) r[4*$urandom_range(0, 4) +: 4] = 4'($urandom_range(10, 15));
         convert(r, "crand");
      end

      // start held high: one conversion every 22 cycles, starts while busy ignored
      @(negedge clk);
      bcd_in = 20'h00255; start = 1'b1;
      ndone = 0; last_done = -1;
      for (int c = 1; c <= 90; c++) begin
         @(posedge clk); #1;
         if (done_a) begin
            ndone++;
            if (last_done >= 0) check("held_period", 32'(c - last_done), 32'd22);
            else check("held_first", 32'(c), 32'd21);
            check("held_bin", 32'(bin_a), 32'd255);
            last_done = c;
         end
      end
      check("held_count", 32'(ndone), 32'd4);
      @(negedge clk); start = 1'b0;
      repeat (25) @(posedge clk);

      // reset in the middle of a conversion
      @(negedge clk); bcd_in = 20'h00777; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_busy", 32'(busy_a), 32'd0);
      check("midrst_bin", 32'(bin_a), 32'd0);
      check("midrst_done", 32'(done_a), 32'd0);
      @(negedge clk); rst = 1'b0;
      ndone = 0;
      for (int c = 0; c < 25; c++) begin
         @(posedge clk); #1;
         if (done_a) ndone++;
      end
      check("midrst_nodone", 32'(ndone), 32'd0);
      convert(20'h00042, "c42");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
